mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter_if.sv | 27 ++
 rtl/mux2_arbiter.sv | 94 +++++++++
 tb/tb_mux2_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_if.sv
// Handshake bundle for the two-requester round-robin arbiter and its registered output slot.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding requesters and consumer.
interface mux2_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sel;
  logic             last;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, sel, last
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, sel, last
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-input round-robin arbiter feeding a single registered output slot.
// The slot refills in the same cycle it drains, so back-to-back transfers have no bubble.
module mux2_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux2_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;

  logic             slot_free_s;
  logic             a_ready_s;
  logic             b_ready_s;
  logic             accept_s;

  // Grant selection. The readys are gated by rst so that nothing is accepted while reset is held.
  always_comb begin
    a_ready_s   = 1'b0;
    b_ready_s   = 1'b0;
    slot_free_s = !rst && ((state_q == EMPTY) || bus.y_ready);
    if (slot_free_s) begin
      if (bus.a_valid && bus.b_valid) begin
        // On a tie, the requester that was not granted most recently wins.
        if (last_q) begin
          a_ready_s = 1'b1;
        end else begin
          b_ready_s = 1'b1;
        end
      end else begin
        a_ready_s = bus.a_valid;
        b_ready_s = bus.b_valid;
      end
    end else begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end
    accept_s = a_ready_s || b_ready_s;
  end

  // Next-state and next-slot contents.
  always_comb begin
    state_d  = state_q;
    y_data_d = y_data_q;
    sel_d    = sel_q;
    last_d   = last_q;
    if (accept_s) begin
      y_data_d = b_ready_s ? bus.b_data : bus.a_data;
      sel_d    = b_ready_s;
      last_d   = b_ready_s;
    end else begin
      y_data_d = y_data_q;
      sel_d    = sel_q;
      last_d   = last_q;
    end
    case (state_q)
      EMPTY:   state_d = accept_s ? FULL : EMPTY;
      FULL:    state_d = (bus.y_ready && !accept_s) ? EMPTY : FULL;
      default: state_d = EMPTY;
    endcase
  end

  // Slot FSM and registered outputs. The async reset discards any held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      y_data_q <= {WIDTH{1'b0}};
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      y_data_q <= y_data_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
    end
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_ready = b_ready_s;
  assign bus.y_valid = (state_q == FULL);
  assign bus.y_data  = y_data_q;
  assign bus.sel     = sel_q;
  assign bus.last    = last_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a transaction-level model of the arbitration rules.
module tb_mux2_arbiter;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  // Reference model state: the beat held in the output slot and the most recent winner.
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sel;
  logic       m_last;

  logic [7:0] seq_obs [4];

  mux2_arbiter_if #(.WIDTH(8)) bus ();

  mux2_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 1'b0;
    m_last  = 1'b1;
  endtask

  task automatic check_slot(input string tag);
    check_eq({tag, "_yv"},   {31'd0, bus.y_valid}, {31'd0, m_valid});
    check_eq({tag, "_yd"},   {24'd0, bus.y_data},  {24'd0, m_data});
    check_eq({tag, "_sel"},  {31'd0, bus.sel},     {31'd0, m_sel});
    check_eq({tag, "_last"}, {31'd0, bus.last},    {31'd0, m_last});
  endtask

  // Runs one clock cycle, starting and ending 1 time unit after a rising edge.
  task automatic cycle(input logic av, input logic [7:0] ad, input logic bv,
                       input logic [7:0] bd, input logic yr);
    int winner;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #1;
    // winner: -1 means no grant, 0 means A, 1 means B.
    if (m_valid && !yr)      winner = -1;
    else if (av && bv)       winner = (m_last == 1'b1) ? 0 : 1;
    else if (av)             winner = 0;
    else if (bv)             winner = 1;
    else                     winner = -1;
    check_eq("a_ready", {31'd0, bus.a_ready}, {31'd0, winner == 0});
    check_eq("b_ready", {31'd0, bus.b_ready}, {31'd0, winner == 1});
    check_eq("one_hot_ready", {31'd0, bus.a_ready && bus.b_ready}, 32'd0);
    check_eq("bp_ready", {31'd0, bus.y_valid && !bus.y_ready && (bus.a_ready || bus.b_ready)}, 32'd0);
    @(posedge clk);
    #1;
    if (winner >= 0) begin
      m_valid = 1'b1;
      m_data  = (winner == 1) ? bd : ad;
      m_sel   = (winner == 1);
      m_last  = (winner == 1);
    end else if (yr) begin
      m_valid = 1'b0;
    end
    check_slot("slot");
  endtask

  // Asserts rst between clock edges, checks the immediate effect, and releases it after an edge.
  task automatic do_reset();
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.y_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_slot("rst_async");
    check_eq("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_eq("rst_b_ready", {31'd0, bus.b_ready}, 32'd0);
    @(posedge clk);
    #1;
    check_slot("rst_held");
    check_eq("rst_held_rdy", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst    = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_data  = 8'h00;
    bus.y_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_slot("init");
    rst = 1'b0;

    // Single requester A.
    cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    check_eq("t33_yd",   {24'd0, bus.y_data}, 32'h3C);
    check_eq("t33_sel",  {31'd0, bus.sel},    32'd0);
    check_eq("t33_last", {31'd0, bus.last},   32'd0);
    check_eq("t33_yv",   {31'd0, bus.y_valid}, 32'd1);

    // Both requesters valid: grants alternate starting with A after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
      seq_obs[i] = bus.y_data;
      check_eq("t34_yv", {31'd0, bus.y_valid}, 32'd1);
    end
    check_eq("t34_seq", {seq_obs[0], seq_obs[1], seq_obs[2], seq_obs[3]}, 32'h11221122);

    // Backpressure: the slot holds and no grants are made.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
      check_eq("t35_yd",   {24'd0, bus.y_data}, 32'h22);
      check_eq("t35_last", {31'd0, bus.last},   32'd1);
    end
    cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    check_eq("t35_next", {24'd0, bus.y_data}, 32'h11);
    check_eq("t35_nsel", {31'd0, bus.sel},    32'd0);

    // B is the only requester.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d;
      d = 8'hA0 + i[7:0];
      cycle(1'b0, 8'h00, 1'b1, d, 1'b1);
      check_eq("t36_yd",   {24'd0, bus.y_data}, {24'd0, d});
      check_eq("t36_sel",  {31'd0, bus.sel},    32'd1);
      check_eq("t36_last", {31'd0, bus.last},   32'd1);
    end

    // Drain with no new accept: y_data and sel hold their values.
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check_eq("drain_yv", {31'd0, bus.y_valid}, 32'd0);
    check_eq("drain_yd", {24'd0, bus.y_data},  32'hA2);

    // A beat that is still held is discarded by an asynchronous reset.
    cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    check_eq("t37_pre", {24'd0, bus.y_data}, 32'h55);
    do_reset();
    cycle(1'b1, 8'h77, 1'b1, 8'h88, 1'b1);
    check_eq("t37_tie", {24'd0, bus.y_data}, 32'h77);
    check_eq("t37_sel", {31'd0, bus.sel},    32'd0);

    // Randomized traffic with occasional backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
